// File: rtl/pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear/toggle and a timed one-shot pulse.
// Pin drive is the data register XOR the currently pulsing bit mask.
module pio_out_pulse #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned PULSE_DEFAULT = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  typedef enum logic {IDLE, PULSING} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] pulse_active;
  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  pulse_len;

  logic                  wr_en;
  logic                  pulse_wr;
  logic [DATA_WIDTH-1:0] wd;
  logic                  unused_writedata;

  assign wr_en    = chipselect & ~write_n;
  assign wd       = writedata[DATA_WIDTH-1:0];
  assign pulse_wr = wr_en && (address == 3'd4) && (wd != '0) && (pulse_len != '0);
  assign unused_writedata = ^writedata;

  assign out_port = data_reg ^ pulse_active;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg  <= RESET_VALUE;
      pulse_len <= CNT_WIDTH'(PULSE_DEFAULT);
    end else if (wr_en) begin
      case (address)
        3'd0: data_reg  <= wd;
        3'd1: data_reg  <= data_reg | wd;
        3'd2: data_reg  <= data_reg & ~wd;
        3'd3: data_reg  <= data_reg ^ wd;
        3'd5: pulse_len <= writedata[CNT_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // A retrigger wins over both decrement and expiry, so a write on the final
  // count edge keeps the already-inverted bits alive for a fresh pulse_len.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pulse_active <= '0;
      count        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pulse_wr) begin
            pulse_active <= wd;
            count        <= pulse_len;
            state        <= PULSING;
          end
        end
        PULSING: begin
          if (pulse_wr) begin
            pulse_active <= pulse_active | wd;
            count        <= pulse_len;
          end else if (count > CNT_WIDTH'(1)) begin
            count <= count - CNT_WIDTH'(1);
          end else begin
            pulse_active <= '0;
            count        <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reads are built in a 64-bit scratch word so every field zero-extends or
  // truncates to 32 bits regardless of the parameter values.
  always_comb begin
    logic [63:0] wide;
    wide = '0;
    case (address)
      3'd0: wide[DATA_WIDTH-1:0] = data_reg;
      3'd4: wide[DATA_WIDTH-1:0] = pulse_active;
      3'd5: wide[CNT_WIDTH-1:0]  = pulse_len;
      3'd6: wide[CNT_WIDTH+1:0]  = {count, 1'b0, state == PULSING};
      default: wide = '0;
    endcase
    readdata = wide[31:0];
  end

endmodule
